col_pe_arbiter: RTL
===================

# col_pe_arbiter

Round-robin packet arbiter that shares one `col_pe` column-convolution engine between `N_REQ` independent column-vector streams, for example R/G/B planes or multiple tiles. A requester holds the engine from its first beat through its end-of-file beat. The arbiter then keeps ownership until every result of that packet has been returned, so `col_pe` flush behaviour never mixes streams. It sits between the per-stream column buffers and the single `col_pe` instance, and routes results back to the owning stream.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `DATA_W`, 8: pixel width.
- `KERNEL_H`, 7: column vector length.
- `CNT_W`, 16: width of the beat counters.
- `DRAIN_IDLE`, 4: consecutive `i_pe_vld`-low cycles in DRAIN that force packet completion.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req_vld` in `N_REQ`: per-requester beat valid.
- `i_req_eof` in `N_REQ`: per-requester last beat of packet.
- `i_req_data` in `N_REQ*KERNEL_H*DATA_W`: per-requester column vectors; requester r occupies slice r.
- `o_req_rdy` out `N_REQ`: per-requester accept.
- `o_pe_vld` out 1: beat valid to `col_pe` `i_vld`.
- `o_pe_eof` out 1: to `col_pe` `i_eof`.
- `o_pe_data` out `KERNEL_H*DATA_W`: to `col_pe` `i_data`.
- `i_pe_rdy` in 1: from `col_pe` `o_rdy`.
- `i_pe_vld` in 1: from `col_pe` `o_vld`.
- `i_pe_data` in `DATA_W`: from `col_pe` `o_data`.
- `o_pe_rdy` out 1: to `col_pe` `i_rdy`.
- `o_rsp_vld` out `N_REQ`: per-requester result valid.
- `o_rsp_data` out `DATA_W`: result pixel, shared bus.
- `i_rsp_rdy` in `N_REQ`: per-requester result accept.
- `o_busy` out 1: state is not IDLE.
- `o_owner` out `$clog2(N_REQ)`: current owner index.

## Operation
- FSM states are IDLE, STREAM and DRAIN.
- IDLE:
  - All `o_req_rdy`, `o_pe_vld` and `o_rsp_vld` are 0.
  - If any `i_req_vld` is set, pick the first set bit at or after priority pointer `prio`, wrapping modulo `N_REQ`.
  - Register it into `owner`, clear `in_cnt`, `out_cnt` and `idle_cnt`, and go to STREAM.
- STREAM:
  - `o_pe_vld = i_req_vld[owner]`, `o_pe_eof = i_req_eof[owner]`, `o_pe_data = i_req_data[owner]`.
  - `o_req_rdy[owner] = i_pe_rdy`; all other `o_req_rdy` are 0.
  - `in_cnt` increments on each accepted beat (`o_pe_vld && i_pe_rdy`).
  - An accepted beat with eof set moves the FSM to DRAIN.
- Result path, active in STREAM and DRAIN:
  - `o_rsp_vld[owner] = i_pe_vld`, `o_rsp_data = i_pe_data`, `o_pe_rdy = i_rsp_rdy[owner]`.
  - `out_cnt` increments on each result handshake.
  - In IDLE, `o_pe_rdy = 1` so stray results are discarded.
- DRAIN:
  - Requester side is closed: `o_pe_vld = 0`, all `o_req_rdy = 0`.
  - `idle_cnt` increments while `i_pe_vld = 0` and clears otherwise.
  - Go to IDLE when either:
    - `out_cnt` reaches `in_cnt`, counting a handshake in the current cycle; or
    - `idle_cnt` reaches `DRAIN_IDLE`. This covers packets shorter than the `col_pe` fill depth, whose results the engine drops.
  - On leaving DRAIN, `prio <= (owner+1) mod N_REQ`.
- Counters saturate at all-ones and never wrap. A saturated `in_cnt` is completed by the idle timeout.
- Non-owner requesters see `o_req_rdy = 0` and `o_rsp_vld = 0` at all times.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - state IDLE, `prio` 0, `owner` 0, all counters 0;
  - all `o_req_rdy`, `o_rsp_vld` and `o_pe_vld` 0;
  - `o_pe_rdy` 1, `o_busy` 0.
- Reset mid-packet abandons the packet. The bench must also reset `col_pe`.
- Arbitration latency: request seen in IDLE → owner's `o_req_rdy` can be high on the next cycle.
- Gap between packets: exactly 1 IDLE cycle after DRAIN exits.
- The request and result paths are combinational pass-throughs. The arbiter adds no beat latency; end-to-end latency is the `col_pe` latency.
- `o_req_rdy` and `o_pe_vld` depend on the registered state and owner plus the same-cycle handshake inputs. There is no combinational loop: `col_pe` registers `o_rdy` through its skid buffer.
- eof accepted and the last result handshake in the same cycle: the FSM moves to DRAIN, not IDLE, because DRAIN requires at least one evaluation cycle.
- Simultaneous requests in IDLE: the lowest index at or after `prio` wins. Other requesters hold their valid and data stable until granted.

## Structure
- Shared package `col_pe_pkg`:
  - FSM state typedef (`ARB_IDLE`, `ARB_STREAM`, `ARB_DRAIN`);
  - `ADD_STAGES = 3`;
  - the default `DATA_W` and `KERNEL_H`.
- Sub-module `rr_pick`: combinational N-bit round-robin priority picker (request vector, pointer → one-hot grant plus index). It is reusable by later arbiters.
- The FSM, counters and muxes live in `col_pe_arbiter`.
- A top-level wrapper instantiates the arbiter plus `col_pe` for integration tests.

## Test plan
- Single requester 1, 8-beat packet of all-100 columns, weights default:
  - 8 results appear only on `o_rsp_vld[1]`;
  - `o_busy` drops 1 cycle after the eighth result handshake;
  - `prio` becomes 2.
- Requesters 0 and 2 assert together with `prio = 0`:
  - 0 is served first and 2 afterwards;
  - `o_req_rdy[2]` stays 0 until 0's DRAIN completes;
  - result streams are never interleaved.
- Backpressure: `i_rsp_rdy[owner]` toggles 1-0-1 randomly during STREAM and DRAIN. All results are still delivered in order, and `out_cnt = in_cnt = 8` at exit.
- Short packet, eof on beat 2: the idle timeout ends DRAIN after `DRAIN_IDLE` = 4 low cycles, and the next requester is granted.
- `i_rst_n` pulsed low mid-STREAM:
  - outputs clear asynchronously within the same cycle;
  - after release, state is IDLE and the next grant follows `prio = 0`.
- Fairness: all 3 requesters stream back-to-back 4-beat packets for 30 packets. Grant order is 0,1,2,0,1,2… and each requester receives 10 packets.

Source files
------------

// File: rtl/col_pe_pkg.sv
// Shared types and constants for the col_pe engine and the arbiter that feeds it.
package col_pe_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_STREAM = 2'd1,
      ARB_DRAIN  = 2'd2
   } arb_state_t;

   localparam int ADD_STAGES   = 3;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_KERNEL_H = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_pick #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx
);

   // Scan from farthest to nearest so the closest candidate to the pointer is written last.
   always_comb begin : pick
      logic [IW-1:0] w_pos;
      w_pos   = '0;
      o_grant = '0;
      o_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_pos]) begin
            o_grant        = '0;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
         end
      end
   end

endmodule

// File: rtl/col_pe_arbiter.sv
// Packet-level round-robin arbiter sharing one col_pe engine between N_REQ streams;
// ownership is held until the owner's results have drained so flushes never mix streams.
module col_pe_arbiter
   import col_pe_pkg::*;
#(
   parameter  int N_REQ      = 3,
   parameter  int DATA_W     = DEF_DATA_W,
   parameter  int KERNEL_H   = DEF_KERNEL_H,
   parameter  int CNT_W      = 16,
   parameter  int DRAIN_IDLE = 4,
   localparam int OW         = $clog2(N_REQ),
   localparam int VW         = KERNEL_H * DATA_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_REQ-1:0]      i_req_vld,
   input  logic [N_REQ-1:0]      i_req_eof,
   input  logic [N_REQ*VW-1:0]   i_req_data,
   output logic [N_REQ-1:0]      o_req_rdy,
   output logic                  o_pe_vld,
   output logic                  o_pe_eof,
   output logic [VW-1:0]         o_pe_data,
   input  logic                  i_pe_rdy,
   input  logic                  i_pe_vld,
   input  logic [DATA_W-1:0]     i_pe_data,
   output logic                  o_pe_rdy,
   output logic [N_REQ-1:0]      o_rsp_vld,
   output logic [DATA_W-1:0]     o_rsp_data,
   input  logic [N_REQ-1:0]      i_rsp_rdy,
   output logic                  o_busy,
   output logic [OW-1:0]         o_owner
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t       r_state;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    r_prio;
   logic [CNT_W-1:0] r_in_cnt;
   logic [CNT_W-1:0] r_out_cnt;
   logic [CNT_W-1:0] r_idle_cnt;

   logic [N_REQ-1:0] w_grant;
   logic [OW-1:0]    w_pick_idx;
   logic [VW-1:0]    w_lane [N_REQ];
   logic             w_stream;
   logic             w_active;
   logic             w_in_hs;
   logic             w_out_hs;
   logic             w_done;
   logic [CNT_W-1:0] w_in_next;
   logic [CNT_W-1:0] w_out_next;
   logic [CNT_W-1:0] w_idle_next;

   rr_pick #(.N(N_REQ)) u_pick (
      .i_req   (i_req_vld),
      .i_ptr   (r_prio),
      .o_grant (w_grant),
      .o_idx   (w_pick_idx)
   );

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign w_lane[gi] = i_req_data[gi*VW +: VW];
   end

   assign w_stream   = (r_state == ARB_STREAM);
   assign w_active   = (r_state != ARB_IDLE);

   assign o_pe_vld   = w_stream & i_req_vld[r_owner];
   assign o_pe_eof   = w_stream & i_req_eof[r_owner];
   assign o_pe_data  = w_lane[r_owner];
   assign o_rsp_data = i_pe_data;
   // Outside a packet the engine is always drained so stray results are dropped.
   assign o_pe_rdy   = w_active ? i_rsp_rdy[r_owner] : 1'b1;
   assign o_busy     = w_active;
   assign o_owner    = r_owner;

   assign w_in_hs    = o_pe_vld & i_pe_rdy;
   assign w_out_hs   = w_active & i_pe_vld & i_rsp_rdy[r_owner];

   always_comb begin
      o_req_rdy = '0;
      o_rsp_vld = '0;
      if (w_stream) o_req_rdy[r_owner] = i_pe_rdy;
      if (w_active) o_rsp_vld[r_owner] = i_pe_vld;
   end

   assign w_in_next   = (w_in_hs  && r_in_cnt  != CNT_MAX) ? r_in_cnt  + 1'b1 : r_in_cnt;
   assign w_out_next  = (w_out_hs && r_out_cnt != CNT_MAX) ? r_out_cnt + 1'b1 : r_out_cnt;
   assign w_idle_next = i_pe_vld ? '0 :
                        ((r_idle_cnt != CNT_MAX) ? r_idle_cnt + 1'b1 : r_idle_cnt);

   // Timeout path also covers packets shorter than the engine fill depth, whose results never appear.
   assign w_done = (w_out_next >= r_in_cnt) || (w_idle_next >= CNT_W'(DRAIN_IDLE));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ARB_IDLE;
         r_owner    <= '0;
         r_prio     <= '0;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_idle_cnt <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (|w_grant) begin
                  r_owner    <= w_pick_idx;
                  r_in_cnt   <= '0;
                  r_out_cnt  <= '0;
                  r_idle_cnt <= '0;
                  r_state    <= ARB_STREAM;
               end
            end
            ARB_STREAM: begin
               r_in_cnt  <= w_in_next;
               r_out_cnt <= w_out_next;
               if (w_in_hs && i_req_eof[r_owner]) r_state <= ARB_DRAIN;
            end
            ARB_DRAIN: begin
               r_out_cnt  <= w_out_next;
               r_idle_cnt <= w_idle_next;
               if (w_done) begin
                  r_state <= ARB_IDLE;
                  r_prio  <= (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule
